// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - EX operand forwarding select and load-use/branch hazard control
module forward_hazard_unit #(
    parameter int REG_W      = 3,
    parameter int LOAD_STALL = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_src_a,
    input  logic [REG_W-1:0] id_src_b,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_valid,
    input  logic             branch_taken,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic             use_a;
        logic             use_b;
        logic [REG_W-1:0] dest;
        logic             wr;
        logic             load;
    } stage_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Stall cycles remaining after the first one, which RUN itself provides.
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

    stage_t     id_rec;
    stage_t     ex_rec;
    stage_t     mem_rec;
    stage_t     wb_rec;
    state_t     state;
    logic [2:0] cnt;
    logic       load_use;

    // A producer record feeds a consumer source when it really writes that register.
    function automatic logic rec_match(input stage_t rec, input logic [REG_W-1:0] src,
                                       input logic use_bit);
        logic zero_blocked;
        zero_blocked = (ZERO_REG != 0) && (src == '0);
        return rec.valid && rec.wr && use_bit && (rec.dest == src) && !zero_blocked;
    endfunction

    // Pack the ID-stage fields into the same record shape as the pipeline stages.
    always_comb begin
        id_rec       = '0;
        id_rec.valid = id_valid;
        id_rec.src_a = id_src_a;
        id_rec.src_b = id_src_b;
        id_rec.use_a = id_use_a;
        id_rec.use_b = id_use_b;
        id_rec.dest  = id_dest;
        id_rec.wr    = id_wr;
        id_rec.load  = id_load;
    end

    // The ID instruction needs a load result that is still in EX.
    always_comb begin
        load_use = id_valid && ex_rec.load &&
                   (rec_match(ex_rec, id_src_a, id_use_a) ||
                    rec_match(ex_rec, id_src_b, id_use_b));
    end

    // Operand select for EX: an ALU result in MEM wins over anything in WB; loads come from WB only.
    always_comb begin
        fwd_sel_a = 2'b00;
        fwd_sel_b = 2'b00;
        if (reset) begin
            if (rec_match(mem_rec, ex_rec.src_a, ex_rec.use_a) && !mem_rec.load) begin
                fwd_sel_a = 2'b01;
            end else if (rec_match(wb_rec, ex_rec.src_a, ex_rec.use_a)) begin
                fwd_sel_a = 2'b10;
            end
            if (rec_match(mem_rec, ex_rec.src_b, ex_rec.use_b) && !mem_rec.load) begin
                fwd_sel_b = 2'b01;
            end else if (rec_match(wb_rec, ex_rec.src_b, ex_rec.use_b)) begin
                fwd_sel_b = 2'b10;
            end
        end
    end

    // Hazard controls: a taken branch overrides any stall; FLUSH keeps EX empty for one more cycle.
    always_comb begin
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (!reset) begin
            if_id_stall  = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                STALL: begin
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                FLUSH: begin
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    if (load_use) begin
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    // Hazard state machine with the remaining-stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else if (branch_taken) begin
            state <= FLUSH;
            cnt   <= 3'd0;
        end else begin
            case (state)
                STALL: begin
                    if (cnt <= 3'd1) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    if (load_use) begin
                        cnt   <= STALL_INIT;
                        state <= (STALL_INIT != 3'd0) ? STALL : RUN;
                    end
                end
            endcase
        end
    end

    // Stage records shift every cycle; a bubble turns the incoming EX record into an empty slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_rec  <= '0;
            mem_rec <= '0;
            wb_rec  <= '0;
        end else begin
            wb_rec  <= mem_rec;
            mem_rec <= ex_rec;
            ex_rec  <= id_ex_bubble ? '0 : id_rec;
        end
    end

    // Consumer-side fields of the later stages are kept for completeness but never read.
    logic unused_rec_bits;
    assign unused_rec_bits = ^{mem_rec.src_a, mem_rec.src_b, mem_rec.use_a, mem_rec.use_b,
                               wb_rec.src_a, wb_rec.src_b, wb_rec.use_a, wb_rec.use_b,
                               wb_rec.load};

endmodule
